msrv32_machine_control: RTL and testbench

MSRV32_MACHINE_CONTROL -- requirements
Module: msrv32_machine_control

---
 rtl/msrv32_pkg.sv | 50 +++++
 rtl/msrv32_trap_prioritizer.sv | 54 +++++
 rtl/msrv32_machine_control.sv | 144 ++++++++++++++
 tb/tb_msrv32_machine_control.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared encodings for the machine-mode trap controller
package msrv32_pkg;

  // FSM state encoding
  localparam logic [1:0] STATE_RESET       = 2'b00;
  localparam logic [1:0] STATE_OPERATING   = 2'b01;
  localparam logic [1:0] STATE_TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] STATE_TRAP_RETURN = 2'b11;

  // Next-PC source selects
  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_NEXT = 2'b01;
  localparam logic [1:0] PC_SRC_EPC  = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP = 2'b11;

  // Exception cause codes
  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  // Interrupt cause codes
  localparam logic [3:0] CAUSE_SOFTWARE_INT = 4'd3;
  localparam logic [3:0] CAUSE_TIMER_INT    = 4'd7;
  localparam logic [3:0] CAUSE_EXTERNAL_INT = 4'd11;

  // SYSTEM instruction fields shared by ecall / ebreak / mret
  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [2:0] FUNCT3_PRIV   = 3'b000;

  localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
  localparam logic [6:0] FUNCT7_EBREAK = 7'b0000000;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;

  localparam logic [4:0] RS2_ECALL  = 5'b00000;
  localparam logic [4:0] RS2_EBREAK = 5'b00001;
  localparam logic [4:0] RS2_MRET   = 5'b00010;

  // True when the fields match the common privileged SYSTEM frame
  function automatic logic is_priv_system(input logic [4:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rd);
    return (opcode == OPCODE_SYSTEM) && (funct3 == FUNCT3_PRIV) &&
           (rs1 == 5'd0) && (rd == 5'd0);
  endfunction

endpackage

// File: rtl/msrv32_trap_prioritizer.sv
// rtl/msrv32_trap_prioritizer.sv - picks the winning exception or interrupt and its cause
module msrv32_trap_prioritizer
  import msrv32_pkg::*;
(
  input  logic       misaligned_instr,
  input  logic       illegal_instr,
  input  logic       ebreak,
  input  logic       ecall,
  input  logic       misaligned_store,
  input  logic       misaligned_load,
  input  logic       mie,
  input  logic       meie,
  input  logic       mtie,
  input  logic       msie,
  input  logic       meip,
  input  logic       mtip,
  input  logic       msip,
  output logic       exc,
  output logic       irq,
  output logic       i_or_e,
  output logic [3:0] cause
);

  logic ext_int;
  logic sw_int;
  logic tmr_int;

  assign ext_int = meie & meip;
  assign sw_int  = msie & msip;
  assign tmr_int = mtie & mtip;

  // Exceptions always win over interrupts; each group has a fixed internal order
  always_comb begin
    exc    = misaligned_instr | illegal_instr | ebreak | ecall |
             misaligned_store | misaligned_load;
    irq    = mie & (ext_int | sw_int | tmr_int);
    i_or_e = 1'b0;
    cause  = CAUSE_INSTR_MISALIGNED;
    if (exc) begin
      if (misaligned_instr)      cause = CAUSE_INSTR_MISALIGNED;
      else if (illegal_instr)    cause = CAUSE_ILLEGAL_INSTR;
      else if (ebreak)           cause = CAUSE_BREAKPOINT;
      else if (ecall)            cause = CAUSE_ECALL_M;
      else if (misaligned_store) cause = CAUSE_STORE_MISALIGNED;
      else                       cause = CAUSE_LOAD_MISALIGNED;
    end else if (irq) begin
      i_or_e = 1'b1;
      if (ext_int)     cause = CAUSE_EXTERNAL_INT;
      else if (sw_int) cause = CAUSE_SOFTWARE_INT;
      else             cause = CAUSE_TIMER_INT;
    end
  end

endmodule

// File: rtl/msrv32_machine_control.sv
// rtl/msrv32_machine_control.sv - machine-mode trap entry/return sequencer
module msrv32_machine_control
  import msrv32_pkg::*;
(
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       misaligned_instr_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       trap_taken_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       flush_out,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic [1:0] pc_src_out
);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       priv_sys;
  logic       ecall;
  logic       ebreak;
  logic       mret;
  logic       exc;
  logic       irq;
  logic       trap_i_or_e;
  logic [3:0] trap_cause;
  logic       take_trap;

  assign priv_sys = is_priv_system(opcode_6_to_2_in, funct3_in, rs1_addr_in, rd_addr_in);
  assign ecall    = priv_sys && (funct7_in == FUNCT7_ECALL)  && (rs2_addr_in == RS2_ECALL);
  assign ebreak   = priv_sys && (funct7_in == FUNCT7_EBREAK) && (rs2_addr_in == RS2_EBREAK);
  assign mret     = priv_sys && (funct7_in == FUNCT7_MRET)   && (rs2_addr_in == RS2_MRET);

  msrv32_trap_prioritizer u_prioritizer (
    .misaligned_instr (misaligned_instr_in),
    .illegal_instr    (illegal_instr_in),
    .ebreak           (ebreak),
    .ecall            (ecall),
    .misaligned_store (misaligned_store_in),
    .misaligned_load  (misaligned_load_in),
    .mie              (mie_in),
    .meie             (meie_in),
    .mtie             (mtie_in),
    .msie             (msie_in),
    .meip             (meip_in),
    .mtip             (mtip_in),
    .msip             (msip_in),
    .exc              (exc),
    .irq              (irq),
    .i_or_e           (trap_i_or_e),
    .cause            (trap_cause)
  );

  // Trap requests only matter while executing normally
  assign take_trap = (state == STATE_OPERATING) && (exc || irq);

  // Next-state: trap beats mret, both single-cycle states fall back to OPERATING
  always_comb begin
    next_state = state;
    case (state)
      STATE_RESET:     next_state = STATE_OPERATING;
      STATE_OPERATING: begin
        if (exc || irq) next_state = STATE_TRAP_TAKEN;
        else if (mret)  next_state = STATE_TRAP_RETURN;
      end
      default:         next_state = STATE_OPERATING;
    endcase
  end

  // State register
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) state <= STATE_RESET;
    else                      state <= next_state;
  end

  // Cause/type captured on trap entry and held until the next one
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      cause_out  <= 4'd0;
      i_or_e_out <= 1'b0;
    end else if (take_trap) begin
      cause_out  <= trap_cause;
      i_or_e_out <= trap_i_or_e;
    end
  end

  // Strobes decoded from the state register; instret also needs a clean cycle
  always_comb begin
    pc_src_out      = PC_SRC_BOOT;
    trap_taken_out  = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    flush_out       = 1'b0;
    case (state)
      STATE_RESET: begin
        pc_src_out = PC_SRC_BOOT;
        flush_out  = 1'b1;
      end
      STATE_OPERATING: begin
        pc_src_out      = PC_SRC_NEXT;
        instret_inc_out = !(exc || irq || mret);
      end
      STATE_TRAP_TAKEN: begin
        pc_src_out     = PC_SRC_TRAP;
        trap_taken_out = 1'b1;
        set_epc_out    = 1'b1;
        set_cause_out  = 1'b1;
        mie_clear_out  = 1'b1;
        flush_out      = 1'b1;
      end
      STATE_TRAP_RETURN: begin
        pc_src_out  = PC_SRC_EPC;
        mie_set_out = 1'b1;
        flush_out   = 1'b1;
      end
      default: begin
        pc_src_out = PC_SRC_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_msrv32_machine_control.sv
// tb/tb_msrv32_machine_control.sv - self-checking bench for the trap sequencer
module tb_msrv32_machine_control;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       illegal_instr = 1'b0;
  logic       misaligned_load = 1'b0;
  logic       misaligned_store = 1'b0;
  logic       misaligned_instr = 1'b0;
  logic [4:0] opcode = 5'b00100;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic [4:0] rs1 = 5'd0;
  logic [4:0] rs2 = 5'd0;
  logic [4:0] rd = 5'd0;
  logic       mie = 1'b0, meie = 1'b0, mtie = 1'b0, msie = 1'b0;
  logic       meip = 1'b0, mtip = 1'b0, msip = 1'b0;

  logic       trap_taken, set_epc, set_cause, mie_clear, mie_set;
  logic       instret_inc, flush, i_or_e;
  logic [3:0] cause;
  logic [1:0] pc_src;

  int n_checks = 0;
  int n_fail   = 0;

  msrv32_machine_control dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .illegal_instr_in     (illegal_instr),
    .misaligned_load_in   (misaligned_load),
    .misaligned_store_in  (misaligned_store),
    .misaligned_instr_in  (misaligned_instr),
    .opcode_6_to_2_in     (opcode),
    .funct3_in            (funct3),
    .funct7_in            (funct7),
    .rs1_addr_in          (rs1),
    .rs2_addr_in          (rs2),
    .rd_addr_in           (rd),
    .mie_in               (mie),
    .meie_in              (meie),
    .mtie_in              (mtie),
    .msie_in              (msie),
    .meip_in              (meip),
    .mtip_in              (mtip),
    .msip_in              (msip),
    .trap_taken_out       (trap_taken),
    .set_epc_out          (set_epc),
    .set_cause_out        (set_cause),
    .mie_clear_out        (mie_clear),
    .mie_set_out          (mie_set),
    .instret_inc_out      (instret_inc),
    .flush_out            (flush),
    .i_or_e_out           (i_or_e),
    .cause_out            (cause),
    .pc_src_out           (pc_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_BOOT, M_RUN, M_TRAP, M_RET} mode_t;
  mode_t      m_mode  = M_BOOT;
  logic [3:0] m_cause = 4'd0;
  logic       m_ie    = 1'b0;

  function automatic logic [31:0] instr_word();
    return {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
  endfunction

  // Scan exceptions then interrupts in architectural priority order
  function automatic void model_trap(output logic take, output logic [3:0] c, output logic ie);
    logic ex_hit [6];
    int   ex_code [6];
    logic in_hit [3];
    int   in_code [3];
    ex_hit  = '{misaligned_instr, illegal_instr, instr_word() == INSTR_EBREAK,
                instr_word() == INSTR_ECALL, misaligned_store, misaligned_load};
    ex_code = '{0, 2, 3, 11, 6, 4};
    in_hit  = '{meie && meip, msie && msip, mtie && mtip};
    in_code = '{11, 3, 7};
    take = 1'b0;
    c    = 4'd0;
    ie   = 1'b0;
    for (int i = 0; i < 6; i++)
      if (ex_hit[i] && !take) begin
        take = 1'b1;
        c    = 4'(ex_code[i]);
      end
    if (mie)
      for (int i = 0; i < 3; i++)
        if (in_hit[i] && !take) begin
          take = 1'b1;
          ie   = 1'b1;
          c    = 4'(in_code[i]);
        end
  endfunction

  always @(posedge clk or posedge rst) begin
    logic       t;
    logic [3:0] c;
    logic       ie;
    if (rst) begin
      m_mode  = M_BOOT;
      m_cause = 4'd0;
      m_ie    = 1'b0;
    end else begin
      case (m_mode)
        M_RUN: begin
          model_trap(t, c, ie);
          if (t) begin
            m_mode  = M_TRAP;
            m_cause = c;
            m_ie    = ie;
          end else if (instr_word() == INSTR_MRET) begin
            m_mode = M_RET;
          end
        end
        default: m_mode = M_RUN;
      endcase
    end
  end

  // Every falling edge: all outputs against the model
  always @(negedge clk) begin
    logic       t;
    logic [3:0] c;
    logic       ie;
    logic [1:0] exp_pc;
    model_trap(t, c, ie);
    case (m_mode)
      M_BOOT:  exp_pc = 2'd0;
      M_RUN:   exp_pc = 2'd1;
      M_TRAP:  exp_pc = 2'd3;
      default: exp_pc = 2'd2;
    endcase
    check("m_pc_src",      {2'b0, pc_src}, {2'b0, exp_pc});
    check("m_trap_taken",  {3'b0, trap_taken}, {3'b0, m_mode == M_TRAP});
    check("m_set_epc",     {3'b0, set_epc},    {3'b0, m_mode == M_TRAP});
    check("m_set_cause",   {3'b0, set_cause},  {3'b0, m_mode == M_TRAP});
    check("m_mie_clear",   {3'b0, mie_clear},  {3'b0, m_mode == M_TRAP});
    check("m_mie_set",     {3'b0, mie_set},    {3'b0, m_mode == M_RET});
    check("m_flush",       {3'b0, flush},      {3'b0, m_mode != M_RUN});
    check("m_instret_inc", {3'b0, instret_inc},
          {3'b0, m_mode == M_RUN && !t && instr_word() != INSTR_MRET});
    check("m_cause",       cause, m_cause);
    check("m_i_or_e",      {3'b0, i_or_e}, {3'b0, m_ie});
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_instr(input logic [31:0] w);
    funct7 = w[31:25];
    rs2    = w[24:20];
    rs1    = w[19:15];
    funct3 = w[14:12];
    rd     = w[11:7];
    opcode = w[6:2];
  endtask

  task automatic clear_all();
    set_instr(INSTR_NOP);
    {misaligned_instr, illegal_instr, misaligned_store, misaligned_load} = 4'b0;
    {mie, meie, mtie, msie, meip, mtip, msip} = 7'b0;
  endtask

  typedef struct {
    logic [3:0]  ex;    // instr, illegal, store, load
    logic [31:0] instr;
    logic [2:0]  irqs;  // ext, sw, timer
    logic [3:0]  cause;
    logic        ie;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs = '{
      '{4'b0100, INSTR_NOP,    3'b000, 4'd2,  1'b0},
      '{4'b0000, INSTR_ECALL,  3'b000, 4'd11, 1'b0},
      '{4'b0000, INSTR_EBREAK, 3'b000, 4'd3,  1'b0},
      '{4'b0110, INSTR_NOP,    3'b000, 4'd2,  1'b0},
      '{4'b0010, INSTR_NOP,    3'b000, 4'd6,  1'b0},
      '{4'b0001, INSTR_NOP,    3'b000, 4'd4,  1'b0},
      '{4'b1100, INSTR_NOP,    3'b000, 4'd0,  1'b0},
      '{4'b0011, INSTR_NOP,    3'b000, 4'd6,  1'b0},
      '{4'b0010, INSTR_ECALL,  3'b000, 4'd11, 1'b0},
      '{4'b0000, INSTR_NOP,    3'b011, 4'd3,  1'b1},
      '{4'b0000, INSTR_NOP,    3'b001, 4'd7,  1'b1},
      '{4'b0001, INSTR_NOP,    3'b110, 4'd4,  1'b0}
    };

    clear_all();
    rst = 1'b1;
    repeat (2) tick();
    settle();
    check("rst_pc_src", {2'b0, pc_src}, 4'd0);
    check("rst_flush",  {3'b0, flush}, 4'd1);
    check("rst_cause",  cause, 4'd0);

    // Release: one more boot cycle, then normal execution
    tick();
    rst = 1'b0;
    settle();
    check("boot_pc_src", {2'b0, pc_src}, 4'd0);
    check("boot_flush",  {3'b0, flush}, 4'd1);
    tick();
    settle();
    check("op_pc_src",  {2'b0, pc_src}, 4'd1);
    check("op_instret", {3'b0, instret_inc}, 4'd1);

    // Illegal instruction
    illegal_instr = 1'b1;
    settle();
    check("ill_instret_low", {3'b0, instret_inc}, 4'd0);
    tick();
    illegal_instr = 1'b0;
    settle();
    check("ill_trap_taken", {3'b0, trap_taken}, 4'd1);
    check("ill_cause",      cause, 4'd2);
    check("ill_i_or_e",     {3'b0, i_or_e}, 4'd0);
    check("ill_pc_src",     {2'b0, pc_src}, 4'd3);
    check("ill_set_epc",    {3'b0, set_epc}, 4'd1);
    check("ill_mie_clear",  {3'b0, mie_clear}, 4'd1);
    tick();
    settle();
    check("ill_back_pc_src", {2'b0, pc_src}, 4'd1);
    check("ill_hold_cause",  cause, 4'd2);

    // External + timer interrupt with global enable
    {mie, meie, meip, mtie, mtip} = 5'b11111;
    tick();
    clear_all();
    settle();
    check("irq_trap_taken", {3'b0, trap_taken}, 4'd1);
    check("irq_cause",      cause, 4'd11);
    check("irq_i_or_e",     {3'b0, i_or_e}, 4'd1);
    tick();

    // Same pending set, global enable off: ignored
    {meie, meip, mtie, mtip} = 4'b1111;
    settle();
    check("mie0_instret", {3'b0, instret_inc}, 4'd1);
    tick();
    settle();
    check("mie0_no_trap", {3'b0, trap_taken}, 4'd0);
    check("mie0_pc_src",  {2'b0, pc_src}, 4'd1);
    clear_all();

    // mret
    set_instr(INSTR_MRET);
    tick();
    clear_all();
    settle();
    check("mret_pc_src",  {2'b0, pc_src}, 4'd2);
    check("mret_mie_set", {3'b0, mie_set}, 4'd1);
    check("mret_flush",   {3'b0, flush}, 4'd1);
    tick();
    settle();
    check("mret_back", {2'b0, pc_src}, 4'd1);

    // mret with misaligned load: trap wins; mret held during TRAP_TAKEN is ignored
    set_instr(INSTR_MRET);
    misaligned_load = 1'b1;
    tick();
    misaligned_load = 1'b0;
    settle();
    check("mretld_trap",  {3'b0, trap_taken}, 4'd1);
    check("mretld_cause", cause, 4'd4);
    check("mretld_pc",    {2'b0, pc_src}, 4'd3);
    tick();
    clear_all();
    settle();
    check("mretld_no_ret", {2'b0, pc_src}, 4'd1);
    tick();

    // Cause priority table
    foreach (vecs[i]) begin
      {misaligned_instr, illegal_instr, misaligned_store, misaligned_load} = vecs[i].ex;
      set_instr(vecs[i].instr);
      mie = 1'b1;
      {meie, meip} = {2{vecs[i].irqs[2]}};
      {msie, msip} = {2{vecs[i].irqs[1]}};
      {mtie, mtip} = {2{vecs[i].irqs[0]}};
      tick();
      clear_all();
      settle();
      check($sformatf("vec%0d_trap", i),   {3'b0, trap_taken}, 4'd1);
      check($sformatf("vec%0d_cause", i),  cause, vecs[i].cause);
      check($sformatf("vec%0d_i_or_e", i), {3'b0, i_or_e}, {3'b0, vecs[i].ie});
      tick();
      settle();
      check($sformatf("vec%0d_back", i), {2'b0, pc_src}, 4'd1);
    end

    // Asynchronous reset in the middle of TRAP_TAKEN
    illegal_instr = 1'b1;
    tick();
    illegal_instr = 1'b0;
    settle();
    check("arst_pre_trap", {3'b0, trap_taken}, 4'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_trap_taken", {3'b0, trap_taken}, 4'd0);
    check("arst_cause",      cause, 4'd0);
    check("arst_i_or_e",     {3'b0, i_or_e}, 4'd0);
    check("arst_pc_src",     {2'b0, pc_src}, 4'd0);
    check("arst_flush",      {3'b0, flush}, 4'd1);
    tick();
    rst = 1'b0;
    tick();
    settle();
    check("arst_recover", {2'b0, pc_src}, 4'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
